// File: rtl/sid_osc_pkg.sv
// Shared definitions for the SID-style oscillator bank: register map, control bits, noise LFSR.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sid_osc_pkg;

    // Per-voice register addresses on the write port
    localparam logic [2:0] REG_FREQ_LO = 3'd0;
    localparam logic [2:0] REG_FREQ_HI = 3'd1;
    localparam logic [2:0] REG_PW_LO   = 3'd2;
    localparam logic [2:0] REG_PW_HI   = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;

    // Control register bit positions
    localparam int CTRL_NOISE = 7;
    localparam int CTRL_PULSE = 6;
    localparam int CTRL_SAW   = 5;
    localparam int CTRL_TRI   = 4;
    localparam int CTRL_TEST  = 3;
    localparam int CTRL_RING  = 2;
    localparam int CTRL_SYNC  = 1;
    localparam int CTRL_GATE  = 0;

    // Noise generator
    localparam int              LFSR_W    = 23;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFFF;

    // Sweep FSM states
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SWEEP = 1'b1;

    // One noise clock: shift left, feedback is bit22 ^ bit17
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[22] ^ s[17]};
    endfunction

    // Noise output tap list, MSB first: 20,18,14,11,9,5,2,0
    function automatic logic [7:0] lfsr_taps(input logic [LFSR_W-1:0] s);
        return {s[20], s[18], s[14], s[11], s[9], s[5], s[2], s[0]};
    endfunction

endpackage

// File: rtl/sid_osc_wave.sv
// Single-voice waveform combiner: saw, triangle (with ring mod), pulse and noise, ANDed together.
// Latency: purely combinational, zero cycles; the caller registers the result.
// Backpressure: none, evaluated every cycle for whichever voice the bank is processing.
module sid_osc_wave
    import sid_osc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OUT_W = 12
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic              noise_en_i,
    input  logic              pulse_en_i,
    input  logic              saw_en_i,
    input  logic              tri_en_i,
    input  logic              test_i,
    input  logic              ring_i,
    input  logic              ring_msb_i,
    input  logic [11:0]       pw_i,
    input  logic [LFSR_W-1:0] lfsr_i,
    output logic [OUT_W-1:0]  wave_o
);

    logic             tri_m;
    logic [OUT_W-1:0] saw_w;
    logic [OUT_W-1:0] tri_w;
    logic [OUT_W-1:0] pulse_w;
    logic [OUT_W-1:0] noise_w;
    logic [11:0]      noise12;
    logic             unused_acc_lo;

    // Low accumulator bits only carry phase precision, never reach the output
    assign unused_acc_lo = ^acc_i[ACC_W-13:0];

    // Build each component and AND together the selected ones
    always_comb begin
        saw_w   = acc_i[ACC_W-1 -: OUT_W];
        tri_m   = acc_i[ACC_W-1] ^ (ring_i & ring_msb_i);
        tri_w   = {acc_i[ACC_W-2 -: OUT_W-1] ^ {(OUT_W-1){tri_m}}, 1'b0};
        pulse_w = (test_i || (acc_i[ACC_W-1 -: 12] >= pw_i)) ? '1 : '0;
        noise12 = {lfsr_taps(lfsr_i), 4'b0000};
        noise_w = OUT_W'(noise12 >> (12 - OUT_W));
        wave_o  = '1;
        if (saw_en_i)   wave_o = wave_o & saw_w;
        if (tri_en_i)   wave_o = wave_o & tri_w;
        if (pulse_en_i) wave_o = wave_o & pulse_w;
        if (noise_en_i) wave_o = wave_o & noise_w;
        if (!(saw_en_i || tri_en_i || pulse_en_i || noise_en_i)) wave_o = '0;
    end

endmodule

// File: rtl/sid_osc_bank.sv
// Time-multiplexed SID-style oscillator bank: one voice per clock after each ce_1m tick.
// Latency: voice v sample appears v+1 clocks after the tick edge; wave_valid pulses once per voice.
// Backpressure: none; ticks arriving mid-sweep are dropped and flagged on sticky overrun.
module sid_osc_bank
    import sid_osc_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 12,
    localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce_1m,
    input  logic                  wr_en,
    input  logic [VW-1:0]         wr_voice,
    input  logic [2:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wave_valid,
    output logic [VW-1:0]         wave_voice,
    output logic [OUT_W-1:0]      wave_data,
    output logic [NUM_VOICES-1:0] msb_out,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

    // Register file and per-voice oscillator state
    logic [7:0]            freq_lo_q [NUM_VOICES];
    logic [7:0]            freq_hi_q [NUM_VOICES];
    logic [7:0]            pw_lo_q   [NUM_VOICES];
    logic [3:0]            pw_hi_q   [NUM_VOICES];
    logic [7:0]            ctrl_q    [NUM_VOICES];
    logic [ACC_W-1:0]      acc_q     [NUM_VOICES];
    logic [LFSR_W-1:0]     lfsr_q    [NUM_VOICES];
    logic [NUM_VOICES-1:0] msb_lat_q;
    logic [NUM_VOICES-1:0] msb_prv_q;

    // Sweep control and output registers
    state_t           state_q, state_d;
    logic [VW-1:0]    cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             wave_valid_q;
    logic [VW-1:0]    wave_voice_q;
    logic [OUT_W-1:0] wave_data_q;

    // Datapath for the voice currently being processed
    logic [VW-1:0]     src_v;
    logic [7:0]        cur_ctrl;
    logic              src_lat;
    logic              src_prv;
    logic [ACC_W-1:0]  acc_old;
    logic [ACC_W-1:0]  acc_new;
    logic [LFSR_W-1:0] lfsr_new;
    logic [OUT_W-1:0]  wave_new;
    logic              proc;
    logic              last_v;
    logic              wr_ok;
    logic              unused_gate;

    assign proc        = (state_q == ST_SWEEP);
    assign last_v      = (cnt_q == LAST_V);
    assign wr_ok       = wr_en && (int'(wr_voice) < NUM_VOICES);
    assign unused_gate = cur_ctrl[CTRL_GATE];

    assign busy       = proc;
    assign overrun    = overrun_q;
    assign wave_valid = wave_valid_q;
    assign wave_voice = wave_voice_q;
    assign wave_data  = wave_data_q;
    assign msb_out    = msb_lat_q;

    // Next accumulator / LFSR for the current voice; sync source is the previous voice (wrapping)
    always_comb begin
        src_v    = (cnt_q == '0) ? LAST_V : cnt_q - VW'(1);
        cur_ctrl = ctrl_q[cnt_q];
        src_lat  = msb_lat_q[src_v];
        src_prv  = msb_prv_q[src_v];
        acc_old  = acc_q[cnt_q];
        if (cur_ctrl[CTRL_TEST]) begin
            acc_new = '0;
        end else if (cur_ctrl[CTRL_SYNC] && src_lat && !src_prv) begin
            acc_new = '0;
        end else begin
            acc_new = acc_old + ACC_W'({freq_hi_q[cnt_q], freq_lo_q[cnt_q]});
        end
        if (cur_ctrl[CTRL_TEST]) begin
            lfsr_new = LFSR_SEED;
        end else if (!acc_old[ACC_W-5] && acc_new[ACC_W-5]) begin
            lfsr_new = lfsr_step(lfsr_q[cnt_q]);
        end else begin
            lfsr_new = lfsr_q[cnt_q];
        end
    end

    sid_osc_wave #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_wave (
        .acc_i      (acc_new),
        .noise_en_i (cur_ctrl[CTRL_NOISE]),
        .pulse_en_i (cur_ctrl[CTRL_PULSE]),
        .saw_en_i   (cur_ctrl[CTRL_SAW]),
        .tri_en_i   (cur_ctrl[CTRL_TRI]),
        .test_i     (cur_ctrl[CTRL_TEST]),
        .ring_i     (cur_ctrl[CTRL_RING]),
        .ring_msb_i (src_lat),
        .pw_i       ({pw_hi_q[cnt_q], pw_lo_q[cnt_q]}),
        .lfsr_i     (lfsr_new),
        .wave_o     (wave_new)
    );

    // Sweep FSM: a tick on the last-voice edge chains straight into the next sweep
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        if (state_q == ST_IDLE) begin
            if (ce_1m) begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        end else if (last_v) begin
            cnt_d   = '0;
            state_d = ce_1m ? ST_SWEEP : ST_IDLE;
        end else begin
            cnt_d = cnt_q + VW'(1);
            if (ce_1m) overrun_d = 1'b1;
        end
    end

    // FSM and sticky overrun state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Register the sample of the voice processed on this edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wave_valid_q <= 1'b0;
            wave_voice_q <= '0;
            wave_data_q  <= '0;
        end else begin
            wave_valid_q <= proc;
            if (proc) begin
                wave_voice_q <= cnt_q;
                wave_data_q  <= wave_new;
            end
        end
    end

    // Advance the processed voice's accumulator, LFSR and MSB history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                acc_q[i]  <= '0;
                lfsr_q[i] <= LFSR_SEED;
            end
            msb_lat_q <= '0;
            msb_prv_q <= '0;
        end else if (proc) begin
            acc_q[cnt_q]     <= acc_new;
            lfsr_q[cnt_q]    <= lfsr_new;
            msb_prv_q[cnt_q] <= msb_lat_q[cnt_q];
            msb_lat_q[cnt_q] <= acc_new[ACC_W-1];
        end
    end

    // Register-file writes; allowed in any state, processing sees the pre-write value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_lo_q[i] <= '0;
                freq_hi_q[i] <= '0;
                pw_lo_q[i]   <= '0;
                pw_hi_q[i]   <= '0;
                ctrl_q[i]    <= '0;
            end
        end else if (wr_ok) begin
            case (wr_addr)
                REG_FREQ_LO: freq_lo_q[wr_voice] <= wr_data;
                REG_FREQ_HI: freq_hi_q[wr_voice] <= wr_data;
                REG_PW_LO:   pw_lo_q[wr_voice]   <= wr_data;
                REG_PW_HI:   pw_hi_q[wr_voice]   <= wr_data[3:0];
                REG_CTRL:    ctrl_q[wr_voice]    <= wr_data;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_osc_bank.sv
// Self-checking bench for sid_osc_bank with a behavioural per-voice reference model.
// Latency: checks voice v sample v+1 clocks after the tick edge.
// Backpressure: n/a; all waits are fixed clock counts.
module tb_sid_osc_bank;

    localparam int NV = 3;
    localparam int VW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          ce_1m;
    logic          wr_en;
    logic [VW-1:0] wr_voice;
    logic [2:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          wave_valid;
    logic [VW-1:0] wave_voice;
    logic [11:0]   wave_data;
    logic [NV-1:0] msb_out;
    logic          busy;
    logic          overrun;

    sid_osc_bank #(
        .NUM_VOICES(NV),
        .ACC_W     (24),
        .OUT_W     (12)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ce_1m      (ce_1m),
        .wr_en      (wr_en),
        .wr_voice   (wr_voice),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wave_valid (wave_valid),
        .wave_voice (wave_voice),
        .wave_data  (wave_data),
        .msb_out    (msb_out),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid = 0;

    // Free-running count of wave_valid pulses
    always @(negedge clock) if (wave_valid === 1'b1) n_valid++;

    // Reference model state
    int unsigned m_freq [NV];
    int unsigned m_pw   [NV];
    int unsigned m_ctrl [NV];
    int unsigned m_acc  [NV];
    int unsigned m_lfsr [NV];
    bit          m_lat  [NV];
    bit          m_prv  [NV];
    int unsigned exp_wave [NV];
    int unsigned obs_wave [NV];
    int          noise_tap [8] = '{20, 18, 14, 11, 9, 5, 2, 0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_freq[v] = 0; m_pw[v] = 0; m_ctrl[v] = 0; m_acc[v] = 0;
            m_lfsr[v] = 32'h7FFFFF; m_lat[v] = 0; m_prv[v] = 0;
        end
    endtask

    task automatic model_write(input int v, input int a, input int unsigned d);
        if (v >= NV) return;
        case (a)
            0: m_freq[v] = (m_freq[v] & 32'hFF00) | d;
            1: m_freq[v] = (m_freq[v] & 32'h00FF) | (d << 8);
            2: m_pw[v]   = (m_pw[v] & 32'hF00) | d;
            3: m_pw[v]   = (m_pw[v] & 32'h0FF) | ((d & 15) << 8);
            4: m_ctrl[v] = d;
            default: ;
        endcase
    endtask

    // One tick: every voice in order, computing its expected 12-bit sample
    task automatic model_tick();
        for (int v = 0; v < NV; v++) begin
            int          s;
            bit          sl, sp, test, sync, ring;
            int unsigned old_a, a, l, top12, saw_v, tri_v, pul_v, noi_v, w;
            bit          m, any;
            s     = (v == 0) ? NV - 1 : v - 1;
            sl    = m_lat[s];
            sp    = m_prv[s];
            test  = m_ctrl[v][3];
            ring  = m_ctrl[v][2];
            sync  = m_ctrl[v][1];
            old_a = m_acc[v];
            if (test)                   a = 0;
            else if (sync && sl && !sp) a = 0;
            else                        a = (old_a + m_freq[v]) % (1 << 24);
            l = m_lfsr[v];
            if (test) l = 32'h7FFFFF;
            else if (((old_a >> 19) & 1) == 0 && ((a >> 19) & 1) == 1)
                l = ((l << 1) | (((l >> 22) ^ (l >> 17)) & 1)) & 32'h7FFFFF;
            m_lfsr[v] = l;
            m_acc[v]  = a;
            m_prv[v]  = m_lat[v];
            m_lat[v]  = (a >> 23) & 1;
            top12 = a >> 12;
            saw_v = top12;
            m     = ((a >> 23) & 1) ^ (ring & sl);
            tri_v = ((top12 ^ (m ? 32'hFFF : 32'h0)) << 1) & 32'hFFF;
            pul_v = (test || top12 >= m_pw[v]) ? 32'hFFF : 32'h0;
            noi_v = 0;
            for (int i = 0; i < 8; i++) noi_v |= ((l >> noise_tap[i]) & 1) << (11 - i);
            w = 32'hFFF; any = 0;
            if (m_ctrl[v][5]) begin w &= saw_v; any = 1; end
            if (m_ctrl[v][4]) begin w &= tri_v; any = 1; end
            if (m_ctrl[v][6]) begin w &= pul_v; any = 1; end
            if (m_ctrl[v][7]) begin w &= noi_v; any = 1; end
            exp_wave[v] = any ? w : 0;
        end
    endtask

    task automatic wr_reg(input int v, input int a, input int unsigned d);
        @(negedge clock);
        wr_en = 1'b1; wr_voice = VW'(v); wr_addr = 3'(a); wr_data = 8'(d);
        @(negedge clock);
        wr_en = 1'b0;
        model_write(v, a, d & 32'hFF);
    endtask

    task automatic reset_all();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // start: pulse ce_1m first; chain: raise ce_1m so it lands on the last-voice edge
    task automatic do_tick(input bit start, input bit chain);
        if (start) begin
            @(negedge clock); ce_1m = 1'b1;
            @(negedge clock); ce_1m = 1'b0;
        end
        model_tick();
        for (int v = 0; v < NV; v++) begin
            @(posedge clock); #1;
            if (ce_1m) ce_1m = 1'b0;
            check_val("wave_valid", 32'(wave_valid), 1);
            check_val("wave_voice", 32'(wave_voice), v);
            check_val("wave_data", 32'(wave_data), exp_wave[v]);
            check_val("busy", 32'(busy), 32'((v != NV - 1) || chain));
            check_val("msb_out", 32'(msb_out[v]), 32'(m_lat[v]));
            obs_wave[v] = wave_data;
            if (chain && v == NV - 2) begin
                @(negedge clock); ce_1m = 1'b1;
            end
        end
        if (!chain) begin
            @(posedge clock); #1;
            check_val("valid_after", 32'(wave_valid), 0);
            check_val("idle_after", 32'(busy), 0);
        end
    endtask

    initial begin
        int base;
        bit prev_chain;
        reset = 1'b1; ce_1m = 1'b0; wr_en = 1'b0;
        wr_voice = '0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_overrun", 32'(overrun), 0);
        check_val("rst_valid", 32'(wave_valid), 0);
        check_val("rst_voice", 32'(wave_voice), 0);
        check_val("rst_data", 32'(wave_data), 0);
        check_val("rst_msb", 32'(msb_out), 0);
        reset = 1'b0;

        // Saw on voice 0, pulse at 50% on voice 1, silent voice 2
        wr_reg(0, 0, 8'h00); wr_reg(0, 1, 8'h80); wr_reg(0, 4, 8'h20);
        wr_reg(1, 1, 8'h80); wr_reg(1, 2, 8'h00); wr_reg(1, 3, 8'h08); wr_reg(1, 4, 8'h40);
        wr_reg(2, 1, 8'h80);
        for (int t = 1; t <= 512; t++) begin
            do_tick(1'b1, 1'b0);
            if (t == 1)   check_val("saw_t1", obs_wave[0], 32'h008);
            if (t == 2)   check_val("saw_t2", obs_wave[0], 32'h010);
            if (t == 255) check_val("msb_t255", 32'(msb_out[0]), 0);
            if (t == 256) check_val("msb_t256", 32'(msb_out[0]), 1);
            if (t == 512) check_val("saw_wrap", obs_wave[0], 32'h000);
            if (t == 1 || t == 255) check_val("pulse_lo", obs_wave[1], 32'h000);
            if (t == 256 || t == 511) check_val("pulse_hi", obs_wave[1], 32'hFFF);
        end

        // Test bit holds accumulator at zero and forces pulse high
        reset_all();
        wr_reg(0, 1, 8'h80); wr_reg(0, 4, 8'h48);
        do_tick(1'b1, 1'b0);
        check_val("test_pulse", obs_wave[0], 32'hFFF);
        do_tick(1'b1, 1'b0);
        wr_reg(0, 4, 8'h60);
        do_tick(1'b1, 1'b0);
        check_val("test_release", obs_wave[0], 32'h008);

        // Hard sync of voice 0 from voice 2
        reset_all();
        wr_reg(2, 1, 8'h80);
        wr_reg(0, 0, 8'h00); wr_reg(0, 1, 8'h01); wr_reg(0, 4, 8'h22);
        for (int t = 1; t <= 257; t++) begin
            do_tick(1'b1, 1'b0);
            if (t == 256) check_val("sync_pre", obs_wave[0], 32'h010);
            if (t == 257) check_val("sync_clear", obs_wave[0], 32'h000);
        end

        // Random register traffic, including out-of-range voices/addresses and chained ticks
        reset_all();
        for (int r = 0; r < 40; r++) begin
            int nw, nt;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                int v, a;
                int unsigned d;
                v = $urandom_range(0, 3);
                a = $urandom_range(0, 7);
                d = $urandom & 32'hFF;
                if (a == 4 && $urandom_range(0, 7) != 0) d &= 32'hF7;
                wr_reg(v, a, d);
            end
            nt = $urandom_range(1, 12);
            prev_chain = 1'b0;
            for (int k = 0; k < nt; k++) begin
                bit ch;
                ch = (k < nt - 1) && ($urandom_range(0, 1) == 1);
                do_tick(!prev_chain, ch);
                prev_chain = ch;
            end
        end
        check_val("rand_no_overrun", 32'(overrun), 0);

        // Tick two clocks into a sweep is dropped and flagged
        reset_all();
        base = n_valid;
        @(negedge clock); ce_1m = 1'b1;
        @(negedge clock); ce_1m = 1'b0;
        @(negedge clock); ce_1m = 1'b1;
        @(negedge clock); ce_1m = 1'b0;
        repeat (6) @(negedge clock);
        check_val("ovr_pulses", n_valid - base, 3);
        check_val("ovr_flag", 32'(overrun), 1);
        check_val("ovr_idle", 32'(busy), 0);

        // Reset in the middle of a sweep abandons it at once
        @(negedge clock); ce_1m = 1'b1;
        @(negedge clock); ce_1m = 1'b0;
        @(posedge clock); #1;
        check_val("mid_valid", 32'(wave_valid), 1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_valid", 32'(wave_valid), 0);
        check_val("mid_rst_ovr", 32'(overrun), 0);
        base = n_valid;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check_val("mid_no_more", n_valid - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
